// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: instruction fields, memory handshake and datapath controls of the multi-cycle MIPS controller
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;
    logic [3:0] state;
    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal, bus_err, state
    );
    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal, bus_err, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multi-cycle MIPS datapath with memory wait-timeout
module mips_multicycle_ctrl #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input logic clk,
    input logic rst,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB,
        BRANCH, IMM_EXEC, IMM_WB, JUMP, JR, ILLEGAL
    } state_t;
    localparam logic [CNT_W-1:0] LIM = CNT_W'(WAIT_LIMIT == 0 ? 0 : WAIT_LIMIT - 1);
    state_t st, nst;
    logic [CNT_W-1:0] cnt;
    logic waiting, timeout;
    logic [5:0] op;
    assign op      = bus.opcode;
    assign waiting = st inside {FETCH, MEM_READ, MEM_WRITE};
    assign timeout = waiting && WAIT_LIMIT != 0 && cnt == LIM && !bus.mem_ready;
    assign bus.state = st;
    // counter is zero outside wait states, so entry to a wait state always starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= FETCH;
            cnt <= '0;
        end else begin
            st  <= nst;
            cnt <= (waiting && !bus.mem_ready && !timeout) ? cnt + CNT_W'(1) : '0;
        end
    end
    always_comb begin
        nst               = FETCH;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 2'b00;
        bus.mem_to_reg    = 2'b00;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.instr_done    = 1'b0;
        bus.illegal       = 1'b0;
        bus.bus_err       = 1'b0;
        if (!rst) begin
            case (st)
                FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                    bus.bus_err   = timeout;
                    nst           = bus.mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    bus.alu_src_b = 2'b11;
                    nst = op == 6'b000000 ? (bus.funct == 6'b001000 ? JR : R_EXEC) :
                          (op == 6'b100011 || op == 6'b101011) ? MEM_ADDR :
                          op == 6'b000100 ? BRANCH :
                          (op == 6'b001000 || op == 6'b001100) ? IMM_EXEC :
                          (op == 6'b000010 || op == 6'b000011) ? JUMP : ILLEGAL;
                end
                MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    nst           = op == 6'b101011 ? MEM_WRITE : MEM_READ;
                end
                MEM_READ: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                    bus.bus_err  = timeout;
                    nst          = bus.mem_ready ? MEM_WB : timeout ? FETCH : MEM_READ;
                end
                MEM_WB: begin
                    bus.mem_to_reg = 2'b01;
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                MEM_WRITE: begin
                    bus.mem_write  = 1'b1;
                    bus.iord       = 1'b1;
                    bus.instr_done = bus.mem_ready;
                    bus.bus_err    = timeout;
                    nst            = (bus.mem_ready || timeout) ? FETCH : MEM_WRITE;
                end
                R_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                    nst           = R_WB;
                end
                R_WB: begin
                    bus.reg_dst    = 2'b01;
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 2'b01;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'b01;
                    bus.instr_done    = 1'b1;
                end
                IMM_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = op == 6'b001100 ? 2'b11 : 2'b00;
                    nst           = IMM_WB;
                end
                IMM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                JUMP: begin
                    bus.pc_write   = 1'b1;
                    bus.pc_source  = 2'b10;
                    bus.instr_done = 1'b1;
                    bus.reg_write  = op == 6'b000011;
                    bus.reg_dst    = op == 6'b000011 ? 2'b10 : 2'b00;
                    bus.mem_to_reg = op == 6'b000011 ? 2'b10 : 2'b00;
                end
                JR: begin
                    bus.alu_src_a  = 1'b1;
                    bus.pc_write   = 1'b1;
                    bus.pc_source  = 2'b11;
                    bus.instr_done = 1'b1;
                end
                ILLEGAL: bus.illegal = 1'b1;
                default: nst = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed checks of every state's outputs, wait/timeout handling and async reset
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int fails = 0;
    logic [20:0] outs, f_rdy, f_wait, dec, maddr, mrd;
    mips_multicycle_ctrl_if bus ();
    mips_multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign outs = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                   bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                   bus.pc_source, bus.instr_done, bus.illegal, bus.bus_err};
    function automatic logic [20:0] ov(input int pw, pwc, io, mr, mw, irw, rd, mtr, rw, asa, asb, aop, ps, dn, il, be);
        return {1'(pw), 1'(pwc), 1'(io), 1'(mr), 1'(mw), 1'(irw), 2'(rd), 2'(mtr), 1'(rw), 1'(asa),
                2'(asb), 2'(aop), 2'(ps), 1'(dn), 1'(il), 1'(be)};
    endfunction
    task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    // inputs change on the falling edge; outputs are checked 1ns later, well clear of the rising edge
    task automatic step(input string tag, input int rdy, input int es, input logic [20:0] eo);
        bus.mem_ready = rdy != 0;
        #1;
        chk({tag, "/state"}, 21'(bus.state), 21'(es));
        chk(tag, outs, eo);
        @(negedge clk);
    endtask
    initial begin
        f_rdy  = ov(1,0,0,1,0,1,0,0,0,0,1,0,0,0,0,0);
        f_wait = ov(0,0,0,1,0,0,0,0,0,0,1,0,0,0,0,0);
        dec    = ov(0,0,0,0,0,0,0,0,0,0,3,0,0,0,0,0);
        maddr  = ov(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0,0);
        mrd    = ov(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'h00;
        bus.funct = 6'h20;
        @(negedge clk);
        step("reset1", 1, 0, '0);
        step("reset2", 1, 0, '0);
        rst = 1'b0;
        step("r.fetch", 1, 0, f_rdy);
        step("r.decode", 1, 1, dec);
        step("r.exec", 1, 6, ov(0,0,0,0,0,0,0,0,0,1,0,2,0,0,0,0));
        step("r.wb", 1, 7, ov(0,0,0,0,0,0,1,0,1,0,0,0,0,1,0,0));
        bus.opcode = 6'h23;
        step("lw.fetch", 1, 0, f_rdy);
        step("lw.decode", 1, 1, dec);
        step("lw.addr", 1, 2, maddr);
        step("lw.wait0", 0, 3, mrd);
        step("lw.wait1", 0, 3, mrd);
        step("lw.wait2", 0, 3, mrd);
        step("lw.ready_at_limit", 1, 3, mrd);
        step("lw.wb", 1, 4, ov(0,0,0,0,0,0,0,1,1,0,0,0,0,1,0,0));
        bus.opcode = 6'h2b;
        step("sw.fetch", 1, 0, f_rdy);
        step("sw.decode", 1, 1, dec);
        step("sw.addr", 1, 2, maddr);
        step("sw.write", 1, 5, ov(0,0,1,0,1,0,0,0,0,0,0,0,0,1,0,0));
        bus.opcode = 6'h04;
        step("beq.fetch", 1, 0, f_rdy);
        step("beq.decode", 1, 1, dec);
        step("beq.branch", 1, 8, ov(0,1,0,0,0,0,0,0,0,1,0,1,1,1,0,0));
        bus.opcode = 6'h08;
        step("addi.fetch", 1, 0, f_rdy);
        step("addi.decode", 1, 1, dec);
        step("addi.exec", 1, 9, ov(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0,0));
        step("addi.wb", 1, 10, ov(0,0,0,0,0,0,0,0,1,0,0,0,0,1,0,0));
        bus.opcode = 6'h0c;
        step("andi.fetch", 1, 0, f_rdy);
        step("andi.decode", 1, 1, dec);
        step("andi.exec", 1, 9, ov(0,0,0,0,0,0,0,0,0,1,2,3,0,0,0,0));
        step("andi.wb", 1, 10, ov(0,0,0,0,0,0,0,0,1,0,0,0,0,1,0,0));
        bus.opcode = 6'h03;
        step("jal.fetch", 1, 0, f_rdy);
        step("jal.decode", 1, 1, dec);
        step("jal.jump", 1, 11, ov(1,0,0,0,0,0,2,2,1,0,0,0,2,1,0,0));
        bus.opcode = 6'h02;
        step("j.fetch", 1, 0, f_rdy);
        step("j.decode", 1, 1, dec);
        step("j.jump", 1, 11, ov(1,0,0,0,0,0,0,0,0,0,0,0,2,1,0,0));
        bus.opcode = 6'h00;
        bus.funct = 6'h08;
        step("jr.fetch", 1, 0, f_rdy);
        step("jr.decode", 1, 1, dec);
        step("jr.jr", 1, 12, ov(1,0,0,0,0,0,0,0,0,1,0,0,3,1,0,0));
        bus.opcode = 6'h3f;
        step("ill.fetch", 1, 0, f_rdy);
        step("ill.decode", 1, 1, dec);
        step("ill.illegal", 1, 13, ov(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0));
        step("fto.wait0", 0, 0, f_wait);
        step("fto.wait1", 0, 0, f_wait);
        step("fto.wait2", 0, 0, f_wait);
        step("fto.timeout", 0, 0, ov(0,0,0,1,0,0,0,0,0,0,1,0,0,0,0,1));
        step("fto.retry", 0, 0, f_wait);
        bus.opcode = 6'h23;
        step("lto.fetch", 1, 0, f_rdy);
        step("lto.decode", 1, 1, dec);
        step("lto.addr", 1, 2, maddr);
        step("lto.wait0", 0, 3, mrd);
        step("lto.wait1", 0, 3, mrd);
        step("lto.wait2", 0, 3, mrd);
        step("lto.timeout", 0, 3, ov(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,1));
        step("lto.refetch", 1, 0, f_rdy);
        step("rst.decode", 1, 1, dec);
        step("rst.addr", 1, 2, maddr);
        step("rst.wait0", 0, 3, mrd);
        rst = 1'b1;
        step("rst.mid", 0, 0, '0);
        rst = 1'b0;
        step("rst.after", 0, 0, f_wait);
        step("rst.after2", 1, 0, f_rdy);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
